// File: rtl/hazard_pkg.sv
// Shared constants, shadow-pipe entry type and helpers for the pipeline hazard controller.
package hazard_pkg;
   localparam int NREG    = 16;
   localparam int RA_W    = $clog2(NREG);
   localparam int CNT_W   = 2;
   localparam int MAXPEND = 3;
   localparam bit R0_ZERO = 1'b1;

   typedef logic [RA_W-1:0] reg_addr_t;

   typedef struct packed {
      logic      valid;
      logic      we;
      reg_addr_t wreg;
   } shadow_t;

   // Entry loaded into stage 3 on a bubble or flush.
   localparam shadow_t SHADOW_NOP = '{valid: 1'b0, we: 1'b0, wreg: '0};

   function automatic logic is_tracked(input reg_addr_t r);
      return !(R0_ZERO && (r == '0));
   endfunction
endpackage

// File: rtl/sb_counter.sv
// Per-register pending-write counter: net +1/-0..2 per edge, clamped to [0, MAXPEND].
// Count is registered; underflow flags this edge's decrement going below zero.
module sb_counter
   import hazard_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic [1:0]       dec,
   output logic [CNT_W-1:0] cnt,
   output logic             underflow
);
   localparam int SW = CNT_W + 2;

   logic [SW-1:0]    up;
   logic [SW-1:0]    down;
   logic [SW-1:0]    diff;
   logic [CNT_W-1:0] cnt_nxt;

   always_comb begin
      up        = SW'(cnt) + SW'(inc);
      down      = SW'(dec);
      diff      = up - down;
      underflow = down > up;
      cnt_nxt   = diff[CNT_W-1:0];
      if (underflow) begin
         cnt_nxt = '0;
      end else if (diff > SW'(MAXPEND)) begin
         cnt_nxt = CNT_W'(MAXPEND);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_nxt;
      end
   end
endmodule

// File: rtl/hazard_ctrl.sv
// Scoreboard hazard/flush controller: counts in-flight register writes from issue to writeback.
// Stall/bubble/flush are combinational on the issue inputs; pend_mask, stall_cnt, haz_err are registered.
module hazard_ctrl
   import hazard_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            issue_valid,
   input  logic            issue_we,
   input  logic [RA_W-1:0] issue_wreg,
   input  logic            issue_rd1_en,
   input  logic [RA_W-1:0] issue_rreg1,
   input  logic            issue_rd2_en,
   input  logic [RA_W-1:0] issue_rreg2,
   input  logic            branch_taken,
   output logic            stall,
   output logic            bubble,
   output logic            flush,
   output logic [NREG-1:0] pend_mask,
   output logic [15:0]     stall_cnt,
   output logic            haz_err
);
   logic [NREG-1:0][CNT_W-1:0] cnt;
   logic [NREG-1:0]            inc;
   logic [NREG-1:0][1:0]       dec;
   logic [NREG-1:0]            underflow;
   shadow_t                    s3, s4, s5, s3_nxt;
   logic                       live;
   logic                       raw, waw, hazard, fire;

   // live keeps stall/bubble/flush low in reset and on the first cycle after release.
   always_comb begin
      raw = (issue_rd1_en && is_tracked(issue_rreg1) && (cnt[issue_rreg1] != '0)) ||
            (issue_rd2_en && is_tracked(issue_rreg2) && (cnt[issue_rreg2] != '0));
      waw = issue_we && is_tracked(issue_wreg) && (cnt[issue_wreg] == CNT_W'(MAXPEND));
      hazard = live && issue_valid && (raw || waw) && !branch_taken;
      stall  = hazard;
      bubble = hazard;
      flush  = live && branch_taken;
      fire   = issue_valid && !stall && !flush;
      s3_nxt = SHADOW_NOP;
      if (fire) begin
         s3_nxt = '{valid: 1'b1, we: issue_we, wreg: issue_wreg};
      end
   end

   // Retire from S5 and flush-kill of S3 can hit the same register, hence a 2-bit decrement.
   always_comb begin
      inc       = '0;
      dec       = '0;
      pend_mask = '0;
      for (int i = 0; i < NREG; i++) begin
         pend_mask[i] = (cnt[i] != '0);
         if (is_tracked(reg_addr_t'(i))) begin
            inc[i] = fire && issue_we && (issue_wreg == reg_addr_t'(i));
            dec[i] = 2'(s5.valid && s5.we && (s5.wreg == reg_addr_t'(i))) +
                     2'(flush && s3.valid && s3.we && (s3.wreg == reg_addr_t'(i)));
         end
      end
   end

   for (genvar g = 0; g < NREG; g++) begin : g_cnt
      sb_counter u_cnt (
         .clk       (clk),
         .rst_n     (rst_n),
         .inc       (inc[g]),
         .dec       (dec[g]),
         .cnt       (cnt[g]),
         .underflow (underflow[g])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         live      <= 1'b0;
         s3        <= SHADOW_NOP;
         s4        <= SHADOW_NOP;
         s5        <= SHADOW_NOP;
         stall_cnt <= '0;
         haz_err   <= 1'b0;
      end else begin
         live <= 1'b1;
         s3   <= s3_nxt;
         s4   <= flush ? SHADOW_NOP : s3;
         s5   <= s4;
         if (stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
         end
         if (|underflow) begin
            haz_err <= 1'b1;
         end
      end
   end
endmodule
